// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and
// default frame geometry.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DEFAULT_B    = 8;
    localparam int DEFAULT_DVSR = 16;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..DVSR-1 and pulses tick on the last count.
// A synchronous clear restarts the period from zero.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int DVSR = DEFAULT_DVSR
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(DVSR - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter that pops bytes straight from a FIFO read port and
// serialises them as start bit, B data bits (LSB first) and one stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int B    = DEFAULT_B,
    parameter int DVSR = DEFAULT_DVSR
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         fifo_empty,
    input  logic [B-1:0] fifo_r_data,
    output logic         fifo_rd,
    output logic         tx,
    output logic         tx_busy,
    output logic         tx_done_tick
);

    localparam int IW = $clog2(B);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [B-1:0]  shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          rd_req;
    logic          tick;
    logic          timer_clr;

    // The timer sits at zero in IDLE and restarts on every state change,
    // so each phase is exactly one bit period long.
    assign timer_clr = (state_q == IDLE) || (state_d != state_q);

    uart_bit_timer #(.DVSR(DVSR)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (timer_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        rd_req  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    rd_req  = 1'b1;
                    shift_d = fifo_r_data;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == IW'(B - 1)) begin
                        idx_d   = '0;
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // The pop strobe must stay low while reset is held, even in IDLE.
    assign fifo_rd      = rd_req && !reset;
    assign tx           = tx_q;
    assign tx_busy      = (state_q != IDLE);
    assign tx_done_tick = (state_q == STOP) && tick;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (B=8, DVSR=4): a cycle-level frame model,
// a behavioural FIFO and a serial decoder check table and random traffic.
module tb_uart_tx;

    localparam int B    = 8;
    localparam int DVSR = 4;
    localparam int L    = DVSR * (B + 2);

    logic         clk = 1'b0;
    logic         reset;
    logic         fifo_empty;
    logic [B-1:0] fifo_r_data;
    logic         fifo_rd;
    logic         tx;
    logic         tx_busy;
    logic         tx_done_tick;

    uart_tx #(.B(B), .DVSR(DVSR)) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .fifo_r_data  (fifo_r_data),
        .fifo_rd      (fifo_rd),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[5];

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         frame_t = 0;
    bit         frame_act = 1'b0;
    logic [7:0] frame_byte = 8'h00;
    bit         scramble_en = 1'b0;
    logic [7:0] fifo_q[$];
    logic [9:0] dec_q[$];
    int         pop_cyc[$];
    int         done_cyc;
    logic       s_rd, s_tx, s_busy;

    bit         dbusy = 1'b0;
    int         dpos  = 0;
    logic [9:0] draw  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A frame popped at cycle frame_t occupies cycles frame_t+1 .. frame_t+L.
    function automatic bit modelBusy();
        int off;
        off = cyc - frame_t;
        return frame_act && (off >= 1) && (off <= L);
    endfunction

    task automatic checkOutput(input bit rst);
        int         off;
        int         k;
        logic       etx;
        logic [3:0] e;
        logic [3:0] a;
        off = cyc - frame_t;
        if (modelBusy()) begin
            k = (off - 1) / DVSR;
            if (k == 0)      etx = 1'b0;
            else if (k <= B) etx = frame_byte[k-1];
            else             etx = 1'b1;
            e = {1'b0, etx, 1'b1, (off == L)};
        end else begin
            e = {(!fifo_empty && !rst), 1'b1, 1'b0, 1'b0};
        end
        a      = {fifo_rd, tx, tx_busy, tx_done_tick};
        s_rd   = fifo_rd;
        s_tx   = tx;
        s_busy = tx_busy;
        if (tx_done_tick === 1'b1) done_cyc = cyc;
        total++;
        if (a !== e) begin
            bad++;
            $display("[TB] FAIL cycle%0d {rd,tx,busy,done}: got %b expected %b", cyc, a, e);
        end
    endtask

    task automatic applyStimulus(input bit rst);
        bit         act;
        logic [7:0] dummy;
        @(negedge clk);
        reset = rst;
        act   = modelBusy();
        if (scramble_en && act) begin
            fifo_empty  = 1'($urandom_range(0, 1));
            fifo_r_data = 8'($urandom);
        end else if (fifo_q.size() == 0) begin
            fifo_empty  = 1'b1;
            fifo_r_data = 8'($urandom);
        end else begin
            fifo_empty  = 1'b0;
            fifo_r_data = fifo_q[0];
        end
        #1;
        checkOutput(rst);
        @(posedge clk);
        if (s_rd === 1'b1 && !(scramble_en && act) && fifo_q.size() > 0) begin
            dummy = fifo_q.pop_front();
            pop_cyc.push_back(cyc);
        end
        if (rst) begin
            frame_act = 1'b0;
        end else if (!act && !fifo_empty) begin
            frame_t    = cyc;
            frame_byte = fifo_r_data;
            frame_act  = 1'b1;
        end
        cyc++;
    endtask

    task automatic drain(input int max_cycles, input string name);
        int n;
        n = 0;
        while (!(fifo_q.size() == 0 && !modelBusy() && !dbusy) && n < max_cycles) begin
            applyStimulus(1'b0);
            n++;
        end
        check({name, "_timeout"}, 32'(n < max_cycles), 32'd1);
        repeat (3) applyStimulus(1'b0);
    endtask

    task automatic checkFrames(input int first, input int n, input string name);
        check({name, "_count"}, dec_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < dec_q.size()) check(name, dec_q[i], vecs[first+i].frame);
        end
    endtask

    // Serial monitor: samples mid-bit, frames collected LSB = start bit.
    always @(negedge clk) begin
        #2;
        if (reset === 1'b1) begin
            dbusy = 1'b0;
        end else if (!dbusy) begin
            if (tx === 1'b0) begin
                dbusy = 1'b1;
                dpos  = 0;
                draw  = '0;
            end
        end else begin
            dpos++;
            if (dpos % DVSR == DVSR / 2) begin
                draw[dpos/DVSR] = tx;
                if (dpos / DVSR == B + 1) begin
                    dec_q.push_back(draw);
                    dbusy = 1'b0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         n;
        int         gap;
        logic [7:0] b;
        logic [7:0] exp_b[$];

        vecs[0] = '{8'hA5, 10'b1_10100101_0};
        vecs[1] = '{8'h00, 10'b1_00000000_0};
        vecs[2] = '{8'hFF, 10'b1_11111111_0};
        vecs[3] = '{8'h3C, 10'b1_00111100_0};
        vecs[4] = '{8'h5A, 10'b1_01011010_0};

        reset       = 1'b1;
        fifo_empty  = 1'b1;
        fifo_r_data = '0;
        repeat (3) applyStimulus(1'b1);

        // Single byte
        dec_q.delete();
        pop_cyc.delete();
        done_cyc = -1;
        fifo_q.push_back(vecs[0].data);
        drain(200, "a5");
        check("a5_pops", pop_cyc.size(), 1);
        gap = (pop_cyc.size() > 0) ? (done_cyc - pop_cyc[0]) : -1;
        check("a5_done_offset", gap, 40);
        checkFrames(0, 1, "a5_frame");

        // Three queued bytes back to back
        dec_q.delete();
        pop_cyc.delete();
        for (int i = 1; i <= 3; i++) fifo_q.push_back(vecs[i].data);
        drain(400, "queued3");
        check("queued3_pops", pop_cyc.size(), 3);
        for (int i = 1; i < 3; i++) begin
            if (i < pop_cyc.size()) check("queued3_gap", pop_cyc[i] - pop_cyc[i-1], 41);
        end
        checkFrames(1, 3, "queued3_frame");

        // Long idle with an empty FIFO
        repeat (100) applyStimulus(1'b0);

        // Reset during data bit 3, then 0x5A must go out intact
        dec_q.delete();
        fifo_q.push_back(8'hC3);
        fifo_q.push_back(vecs[4].data);
        n = 0;
        while (!(modelBusy() && (cyc - frame_t) == 18) && n < 200) begin
            applyStimulus(1'b0);
            n++;
        end
        check("reach_bit3", 32'(n < 200), 32'd1);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        check("abort_tx_busy", {30'd0, s_tx, s_busy}, 32'b10);
        drain(200, "after_reset");
        checkFrames(4, 1, "after_reset_frame");

        // Inputs churn while a frame is in flight
        dec_q.delete();
        scramble_en = 1'b1;
        fifo_q.push_back(8'h96);
        drain(200, "scramble");
        scramble_en = 1'b0;
        check("scramble_count", dec_q.size(), 1);
        if (dec_q.size() > 0) check("scramble_frame", dec_q[0], {1'b1, 8'h96, 1'b0});

        // Full loop: burst of 5 random bytes, then randomly timed writes
        dec_q.delete();
        exp_b.delete();
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            exp_b.push_back(b);
            fifo_q.push_back(b);
        end
        drain(500, "burst5");
        for (int i = 0; i < 15; i++) begin
            repeat ($urandom_range(0, 60)) applyStimulus(1'b0);
            b = 8'($urandom);
            exp_b.push_back(b);
            fifo_q.push_back(b);
        end
        drain(3000, "random");
        check("random_count", dec_q.size(), exp_b.size());
        for (int i = 0; i < exp_b.size(); i++) begin
            if (i < dec_q.size()) check("random_frame", dec_q[i], {1'b1, exp_b[i], 1'b0});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
